// File: rtl/cmd_pkg.sv
// Shared types for the command scheduler: opcodes, FSM states, button bit
// positions and the button-priority decode.
package cmd_pkg;

  localparam int STATE_W = 3;
  localparam int OP_W    = 2;

  localparam int BTN_U = 4;
  localparam int BTN_D = 3;
  localparam int BTN_L = 2;
  localparam int BTN_R = 1;
  localparam int BTN_C = 0;

  typedef enum logic [OP_W-1:0] {
    INC = 2'd0,
    DEC = 2'd1,
    CLR = 2'd2,
    SET = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } fsm_e;

  // Winning opcode when several buttons fire together: L > C > U > D.
  function automatic op_e btnOp(input logic [4:0] btn);
    if (btn[BTN_L]) return CLR;
    if (btn[BTN_C]) return SET;
    if (btn[BTN_U]) return INC;
    return DEC;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small first-word-fall-through FIFO holding queued scheduler commands.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Command scheduler: captures button/clap events into holding registers,
// arbitrates them into a FIFO and executes them against the datapath.
module cmd_scheduler
  import cmd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [4:0]         btn_i,
  input  logic               clap_set_i,
  input  logic               done_i,
  output logic [STATE_W-1:0] state_o,
  output logic               set_o,
  output logic               clr_o,
  output logic               busy_o,
  output logic               drop_o,
  output logic               err_o
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic               btnAny;
  logic               btnMulti;
  logic               btnLost;
  logic               clapLost;
  op_e                btnOpNow;
  logic               unusedBtnR;

  logic               btnHoldValid_q, btnHoldValid_d;
  op_e                btnHoldOp_q, btnHoldOp_d;
  logic               clapHoldValid_q, clapHoldValid_d;
  logic               rrBtn_q, rrBtn_d;
  logic               drop_q;

  logic               grantBtn;
  logic               grantClap;
  logic               fifoPush;
  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [OP_W-1:0]    fifoWrData;
  logic [OP_W-1:0]    fifoRdData;
  op_e                headOp;

  fsm_e               fsm_q;
  op_e                cmd_q;
  logic [STATE_W-1:0] stateVal_q;
  logic               set_q;
  logic               clr_q;
  logic               err_q;
  logic [CNT_W-1:0]   timer_q;

  assign unusedBtnR = btn_i[BTN_R];

  always_comb begin
    btnAny   = btn_i[BTN_L] | btn_i[BTN_C] | btn_i[BTN_U] | btn_i[BTN_D];
    btnMulti = $countones({btn_i[BTN_L], btn_i[BTN_C], btn_i[BTN_U], btn_i[BTN_D]}) > 1;
    btnOpNow = btnOp(btn_i);
    btnLost  = btnAny && (btnHoldValid_q || btnMulti);
    clapLost = clap_set_i && clapHoldValid_q;
  end

  // Round-robin between the two holding registers; fullness is the registered
  // FIFO state, so a same-cycle pop never opens room for a push.
  always_comb begin
    grantBtn   = !fifoFull && btnHoldValid_q && (rrBtn_q || !clapHoldValid_q);
    grantClap  = !fifoFull && clapHoldValid_q && !grantBtn;
    fifoPush   = grantBtn | grantClap;
    fifoWrData = grantBtn ? btnHoldOp_q : SET;

    btnHoldValid_d  = btnHoldValid_q;
    btnHoldOp_d     = btnHoldOp_q;
    clapHoldValid_d = clapHoldValid_q;
    rrBtn_d         = rrBtn_q;

    if (grantBtn) begin
      btnHoldValid_d = 1'b0;
      rrBtn_d        = 1'b0;
    end
    if (grantClap) begin
      clapHoldValid_d = 1'b0;
      rrBtn_d         = 1'b1;
    end
    if (btnAny && !btnHoldValid_q) begin
      btnHoldValid_d = 1'b1;
      btnHoldOp_d    = btnOpNow;
    end
    if (clap_set_i && !clapHoldValid_q) clapHoldValid_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btnHoldValid_q  <= 1'b0;
      btnHoldOp_q     <= INC;
      clapHoldValid_q <= 1'b0;
      rrBtn_q         <= 1'b1;
      drop_q          <= 1'b0;
    end else begin
      btnHoldValid_q  <= btnHoldValid_d;
      btnHoldOp_q     <= btnHoldOp_d;
      clapHoldValid_q <= clapHoldValid_d;
      rrBtn_q         <= rrBtn_d;
      drop_q          <= btnLost | clapLost;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OP_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifoPush),
    .data_i  (fifoWrData),
    .pop_i   (fifoPop),
    .data_o  (fifoRdData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign headOp  = op_e'(fifoRdData);
  assign fifoPop = (fsm_q == IDLE) && !fifoEmpty;

  // The popped command's effect is registered on entry to EXEC, so strobes and
  // state changes are visible during the EXEC cycle itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q      <= IDLE;
      cmd_q      <= INC;
      stateVal_q <= '0;
      set_q      <= 1'b0;
      clr_q      <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (!fifoEmpty) begin
            cmd_q <= headOp;
            fsm_q <= EXEC;
            case (headOp)
              INC:     stateVal_q <= stateVal_q + STATE_W'(1);
              DEC:     stateVal_q <= stateVal_q - STATE_W'(1);
              SET:     set_q      <= 1'b1;
              default: clr_q      <= 1'b1;
            endcase
          end
        end
        EXEC: begin
          set_q <= 1'b0;
          clr_q <= 1'b0;
          if (cmd_q == INC || cmd_q == DEC) begin
            fsm_q <= IDLE;
          end else begin
            fsm_q   <= WAIT;
            timer_q <= '0;
          end
        end
        WAIT: begin
          if (done_i) begin
            fsm_q <= IDLE;
          end else if (timer_q == TIMEOUT_CNT) begin
            err_q <= 1'b1;
            fsm_q <= IDLE;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state_o = stateVal_q;
  assign set_o   = set_q;
  assign clr_o   = clr_q;
  assign drop_o  = drop_q;
  assign err_o   = err_q;
  assign busy_o  = (fsm_q != IDLE) || !fifoEmpty || btnHoldValid_q || clapHoldValid_q;

endmodule
